// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter with pending-register scoreboard (optional REGFILE_WB_BYPASS_EN adds write-stage bypass outputs)
module regfile_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0Valid,
  input  logic [ADDR_W-1:0] req0Addr,
  input  logic [DATA_W-1:0] req0Data,
  output logic              req0Ready,
  input  logic              req1Valid,
  input  logic [ADDR_W-1:0] req1Addr,
  input  logic [DATA_W-1:0] req1Data,
  output logic              req1Ready,
  input  logic              rsvValid,
  input  logic [ADDR_W-1:0] rsvAddr,
  input  logic [ADDR_W-1:0] qAddr1,
  input  logic [ADDR_W-1:0] qAddr2,
  output logic              qBusy1,
  output logic              qBusy2,
  output logic              rfWriteEnable,
  output logic [ADDR_W-1:0] rfWriteAddr,
  output logic [DATA_W-1:0] rfWriteData,
  output logic              badAddr
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic              bypassHit1,
  output logic              bypassHit2,
  output logic [DATA_W-1:0] bypassData1,
  output logic [DATA_W-1:0] bypassData2
`endif
);
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  logic                 last_q, last_d;
  logic                 we_q, we_d, bad_q, bad_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [2**ADDR_W-1:0] busy_ext;
  logic                 gnt0, gnt1, gnt, gnt_ok, rsv_ok;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [DATA_W-1:0]    gnt_data;
  // round-robin grant: on conflict the port that did not win last time goes
  always_comb begin
    gnt0     = req0Valid && (!req1Valid || last_q);
    gnt1     = req1Valid && (!req0Valid || !last_q);
    gnt      = gnt0 || gnt1;
    gnt_addr = gnt1 ? req1Addr : req0Addr;
    gnt_data = gnt1 ? req1Data : req0Data;
    gnt_ok   = {1'b0, gnt_addr} < NR;
    rsv_ok   = {1'b0, rsvAddr} < NR;
    last_d   = gnt ? gnt1 : last_q;
    we_d     = gnt && gnt_ok;
    addr_d   = gnt ? gnt_addr : addr_q;
    data_d   = gnt ? gnt_data : data_q;
    bad_d    = (gnt && !gnt_ok) || (rsvValid && !rsv_ok);
  end
  // scoreboard: write-back clears, reservation sets, and the newer reservation wins a tie
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++)
      busy_d[i] = (rsvValid && rsvAddr == ADDR_W'(i)) || (busy_q[i] && !(gnt && gnt_addr == ADDR_W'(i)));
  end
  // registered write stage, scoreboard and arbitration history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      we_q   <= 1'b0;
      bad_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      bad_q  <= bad_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end
  assign busy_ext      = (2**ADDR_W)'(busy_q);
  assign req0Ready     = gnt0;
  assign req1Ready     = gnt1;
  assign qBusy1        = busy_ext[qAddr1];
  assign qBusy2        = busy_ext[qAddr2];
  assign rfWriteEnable = we_q;
  assign rfWriteAddr   = addr_q;
  assign rfWriteData   = data_q;
  assign badAddr       = bad_q;
`ifdef REGFILE_WB_BYPASS_EN
  assign bypassHit1  = we_q && addr_q == qAddr1;
  assign bypassHit2  = we_q && addr_q == qAddr2;
  assign bypassData1 = data_q;
  assign bypassData2 = data_q;
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 8x16-bit register file. It shares the file's single write port between two requesters: port 0 is ALU write-back and port 1 is load/MEM write-back. Arbitration is round-robin, and the winning write is driven to the file through a registered stage. It also tracks pending destination registers, so the issue stage can detect read-after-write hazards.

Parameters:
DATA_W, 16, write data width
ADDR_W, 4, register address width (matches register-file port width)
NUM_REGS, 8, number of physically implemented registers; valid addresses are 0..NUM_REGS-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0Valid  input  1  ALU write request
req0Addr  input  ADDR_W  ALU destination register
req0Data  input  DATA_W  ALU result
req0Ready  output  1  grant to port 0 (combinational)
req1Valid  input  1  MEM write request
req1Addr  input  ADDR_W  MEM destination register
req1Data  input  DATA_W  load data
req1Ready  output  1  grant to port 1 (combinational)
rsvValid  input  1  issue stage reserves a destination register
rsvAddr  input  ADDR_W  register being reserved
qAddr1  input  ADDR_W  hazard query address 1
qAddr2  input  ADDR_W  hazard query address 2
qBusy1  output  1  register qAddr1 has a pending write
qBusy2  output  1  register qAddr2 has a pending write
rfWriteEnable  output  1  to register file writeEnable
rfWriteAddr  output  ADDR_W  to register file writeAddr
rfWriteData  output  DATA_W  to register file writeData
badAddr  output  1  one-cycle pulse: an accepted write or reservation had an address >= NUM_REGS

Behaviour:
- Reset (async, rst_n=0), all values forced immediately:
  - rfWriteEnable=0, rfWriteAddr=0, rfWriteData=0, badAddr=0
  - busy[NUM_REGS-1:0]=0
  - lastGrant=1, so port 0 wins the first conflict
- Reset mid-operation: in-flight write discarded, no rfWriteEnable pulse after deassert, all reservations lost.
- Handshake:
  - Transfer on port i when reqiValid && reqiReady in the same cycle.
  - Ready is combinational from the valid inputs and lastGrant.
  - At most one grant per cycle. The port write may never stall.
  - A requester holds Valid/Addr/Data stable until it is granted.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both valid: the port that is not lastGrant is granted.
  - lastGrant updates only on a grant.
  - Neither valid: no grant, lastGrant unchanged.
- Write stage, 1-cycle latency:
  - A grant in cycle N produces rfWriteEnable=1 in cycle N+1, with the granted addr/data registered.
  - No grant in cycle N: rfWriteEnable=0 in N+1. Addr/data hold their previous values.
- Scoreboard:
  - At each rising edge, rsvValid with rsvAddr<NUM_REGS sets busy[rsvAddr].
  - A grant with addr<NUM_REGS clears busy[addr] at the same edge.
  - Set and clear on the same register in the same cycle: set wins (the reservation is the newer instruction).
  - Reserving an already-busy register: it stays busy (no counting).
  - A write to a non-busy register is legal and leaves it not busy.
- Query outputs:
  - qBusyK = busy[qAddrK] from the registered state, combinational, with no same-cycle bypass of grants.
  - qAddrK >= NUM_REGS gives qBusyK=0.
- Out-of-range addresses (addr >= NUM_REGS, i.e. bit 3 set at the defaults):
  - Such a write is still granted and consumed, but rfWriteEnable stays 0 in N+1.
  - Such a reservation is ignored.
  - Either case pulses badAddr=1 for one cycle (N+1).

Optional Feature:
REGFILE_WB_BYPASS_EN
- Defined: adds outputs bypassHit1, bypassHit2 (1 bit each) and bypassData1, bypassData2 (DATA_W each).
  - bypassHitK=1 when rfWriteEnable && rfWriteAddr==qAddrK; bypassDataK=rfWriteData.
  - This covers the cycle in which the register file's synchronous read would return stale data.
  - Both outputs are 0 after reset.
- Undefined: these ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, only req0Valid=1, req0Addr=3, req0Data=16'hA5A5 -> req0Ready=1 same cycle; next cycle rfWriteEnable=1, rfWriteAddr=3, rfWriteData=16'hA5A5.
- Both ports valid for 4 cycles (addrs 1 and 2) -> grants alternate 0,1,0,1; rfWriteEnable=1 for 4 consecutive cycles; no cycle with both readies high.
- rsvValid=1, rsvAddr=5 -> next cycle qAddr1=5 gives qBusy1=1; req1 write to 5 granted -> qBusy1=0 the cycle after the grant.
- Same cycle: reservation of reg 4 and granted write to reg 4 -> busy[4] remains 1 afterwards.
- req0Addr=4'd9 granted -> next cycle rfWriteEnable=0, badAddr=1 for exactly one cycle; req0Ready was 1.
- Drop rst_n asynchronously one cycle after a grant -> rfWriteEnable=0 immediately, all qBusy=0, next conflict granted to port 0.
